// File: rtl/corral_pkg.sv
// Shared types and constants for the corral LED display.
package corral_pkg;

    localparam int ARENA_W = 16;
    localparam int IDX_W   = 4;

    typedef enum logic [2:0] {
        DS_IDLE,
        DS_LOAD,
        DS_SHIFT_LO,
        DS_SHIFT_HI,
        DS_LATCH
    } disp_state_t;

    localparam logic [ARENA_W-1:0] PAT_WON_ON = 16'hFFFF;
    localparam logic [ARENA_W-1:0] PAT_LOST_A = 16'hAAAA;
    localparam logic [ARENA_W-1:0] PAT_LOST_B = 16'h5555;

    // Single lit LED at an arena column.
    function automatic logic [ARENA_W-1:0] col_onehot(input logic [IDX_W-1:0] pos);
        return ARENA_W'(1) << pos;
    endfunction

endpackage

// File: rtl/corral_display_if.sv
// Game-status inputs and LED shift-chain outputs of the corral display.
interface corral_display_if;

    logic [3:0] cowboy_pos;
    logic [3:0] horse_pos;
    logic       gameover;
    logic       lostwon;
    logic       ready;
    logic       sr_data;
    logic       sr_clk;
    logic       sr_latch;
    logic       frame_done;

    // Game core side: drives status, observes the LED chain.
    modport master (
        output cowboy_pos, horse_pos, gameover, lostwon, ready,
        input  sr_data, sr_clk, sr_latch, frame_done
    );

    // Display side: consumes status, drives the LED chain.
    modport slave (
        input  cowboy_pos, horse_pos, gameover, lostwon, ready,
        output sr_data, sr_clk, sr_latch, frame_done
    );

endinterface

// File: rtl/corral_pattern.sv
// Combinational renderer: positions and game status to a 16-LED arena image.
module corral_pattern
    import corral_pkg::*;
(
    input  logic [3:0]         cowboy_pos_i,
    input  logic [3:0]         horse_pos_i,
    input  logic               gameover_i,
    input  logic               lostwon_i,
    input  logic               ready_i,
    input  logic               blink_i,
    output logic [ARENA_W-1:0] pattern_o
);

    logic cowboy_lit;

    // Cowboy blinks while the core waits for a move; end screens flash.
    always_comb begin
        pattern_o  = '0;
        cowboy_lit = ready_i ? blink_i : 1'b1;
        if (gameover_i) begin
            if (lostwon_i)
                pattern_o = blink_i ? PAT_WON_ON : '0;
            else
                pattern_o = blink_i ? PAT_LOST_A : PAT_LOST_B;
        end else begin
            // OR keeps a coinciding cowboy/horse column lit.
            pattern_o = col_onehot(horse_pos_i)
                      | (cowboy_lit ? col_onehot(cowboy_pos_i) : '0);
        end
    end

endmodule

// File: rtl/corral_display.sv
// Corral display: snapshots game state each frame and shifts it MSB first
// into a 74HC595-style LED chain, then latches it.
module corral_display
    import corral_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int BLINK_BITS = 20
) (
    input  logic             clock,
    input  logic             reset_n,
    corral_display_if.slave  disp_if
);

    localparam int              DW       = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);

    disp_state_t               state_q, state_d;
    logic [DW-1:0]             div_q, div_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [ARENA_W-1:0]        frame_q, frame_d;
    logic                      sr_data_q, sr_data_d;
    logic                      sr_clk_q, sr_clk_d;
    logic                      sr_latch_q, sr_latch_d;
    logic                      done_q, done_d;
    logic [BLINK_BITS-1:0]     blink_q;
    logic [ARENA_W-1:0]        pattern;
    logic                      div_last;
    logic [IDX_W-1:0]          idx_dec;

    corral_pattern u_pattern (
        .cowboy_pos_i (disp_if.cowboy_pos),
        .horse_pos_i  (disp_if.horse_pos),
        .gameover_i   (disp_if.gameover),
        .lostwon_i    (disp_if.lostwon),
        .ready_i      (disp_if.ready),
        .blink_i      (blink_q[BLINK_BITS-1]),
        .pattern_o    (pattern)
    );

    assign div_last = (div_q == DIV_LAST);
    assign idx_dec  = idx_q - IDX_W'(1);

    // Next state: one divider period per shift-clock half and for the latch.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        idx_d     = idx_q;
        frame_d   = frame_q;
        sr_data_d = sr_data_q;
        done_d    = 1'b0;
        case (state_q)
            DS_IDLE: state_d = DS_LOAD;
            DS_LOAD: begin
                frame_d   = pattern;
                idx_d     = IDX_W'(ARENA_W - 1);
                sr_data_d = pattern[ARENA_W-1];
                div_d     = '0;
                state_d   = DS_SHIFT_LO;
            end
            DS_SHIFT_LO: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = DS_SHIFT_HI;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            DS_SHIFT_HI: begin
                if (div_last) begin
                    div_d = '0;
                    if (idx_q != '0) begin
                        // Data moves on the falling edge, a full half period ahead of the next rise.
                        idx_d     = idx_dec;
                        sr_data_d = frame_q[idx_dec];
                        state_d   = DS_SHIFT_LO;
                    end else begin
                        state_d = DS_LATCH;
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            DS_LATCH: begin
                if (div_last) begin
                    div_d   = '0;
                    done_d  = 1'b1;
                    state_d = DS_IDLE;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            default: state_d = DS_IDLE;
        endcase
        sr_clk_d   = (state_d == DS_SHIFT_HI);
        sr_latch_d = (state_d == DS_LATCH);
    end

    // State and registered outputs; reset drops the chain lines without a latch.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= DS_IDLE;
            div_q      <= '0;
            idx_q      <= '0;
            frame_q    <= '0;
            sr_data_q  <= 1'b0;
            sr_clk_q   <= 1'b0;
            sr_latch_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            idx_q      <= idx_d;
            frame_q    <= frame_d;
            sr_data_q  <= sr_data_d;
            sr_clk_q   <= sr_clk_d;
            sr_latch_q <= sr_latch_d;
            done_q     <= done_d;
        end
    end

    // Free-running blink timer; its MSB is the blink phase.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) blink_q <= '0;
        else          blink_q <= blink_q + BLINK_BITS'(1);
    end

    assign disp_if.sr_data    = sr_data_q;
    assign disp_if.sr_clk     = sr_clk_q;
    assign disp_if.sr_latch   = sr_latch_q;
    assign disp_if.frame_done = done_q;

endmodule

// File: tb/tb_corral_display.sv
// Directed bench for corral_display at CLK_DIV=2, BLINK_BITS=4.
// Blink at each frame's LOAD: counter = 1 + 68*k (mod 16) -> blink = k[1].
module tb_corral_display;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    corral_display_if dif ();

    corral_display #(.CLK_DIV(2), .BLINK_BITS(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .disp_if (dif.slave)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Chain model: shift on each sr_clk rise, summarise each frame at frame_done.
    logic [15:0] cap, done_word;
    int edges, lat_w, len, done_edges, done_lat, done_len, done_cnt, lat_rises;
    logic clk_p, lat_p, done_latp;

    initial begin
        done_cnt = 0; lat_rises = 0;
    end

    always @(negedge clock) begin
        if (!reset_n) begin
            cap <= '0; edges <= 0; lat_w <= 0; len <= 0; clk_p <= 1'b0; lat_p <= 1'b0;
        end else begin
            clk_p <= dif.sr_clk;
            lat_p <= dif.sr_latch;
            if (dif.sr_clk && !clk_p) begin
                cap   <= {cap[14:0], dif.sr_data};
                edges <= edges + 1;
            end
            if (dif.sr_latch) lat_w <= lat_w + 1;
            if (dif.sr_latch && !lat_p) lat_rises <= lat_rises + 1;
            if (dif.frame_done) begin
                done_word  <= cap;
                done_edges <= edges;
                done_lat   <= lat_w;
                done_latp  <= lat_p;
                done_len   <= len;
                done_cnt   <= done_cnt + 1;
                len        <= 1;
                edges      <= 0;
                lat_w      <= 0;
            end else begin
                len <= len + 1;
            end
        end
    end

    task automatic do_reset();
        @(posedge clock); #1;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic wait_frame(input string tag);
        int start;
        bit seen;
        start = done_cnt;
        seen  = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(posedge clock);
            if (done_cnt != start) seen = 1'b1;
        end
        if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
        #1;
    endtask

    task automatic wait_edges(input int n);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(posedge clock); #1;
            if (edges == n) seen = 1'b1;
        end
        if (!seen) chk("edge_wait_timeout", 32'd0, 32'd1);
    endtask

    task automatic set_in(input logic [3:0] cb, input logic [3:0] hp,
                          input logic go, input logic lw, input logic rd);
        dif.cowboy_pos = cb;
        dif.horse_pos  = hp;
        dif.gameover   = go;
        dif.lostwon    = lw;
        dif.ready      = rd;
    endtask

    initial begin
        int lr0;
        set_in(4'd0, 4'd10, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        chk("rst_sr_data",  {31'd0, dif.sr_data},    32'd0);
        chk("rst_sr_clk",   {31'd0, dif.sr_clk},     32'd0);
        chk("rst_sr_latch", {31'd0, dif.sr_latch},   32'd0);
        chk("rst_done",     {31'd0, dif.frame_done}, 32'd0);

        // 1: basic frame shape
        do_reset();
        wait_frame("t1");
        chk("t1_word",  {16'd0, done_word}, 32'h0401);
        chk("t1_edges", done_edges, 16);
        chk("t1_latw",  done_lat, 2);
        chk("t1_latch_then_done", {31'd0, done_latp}, 32'd1);
        chk("t1_len0",  done_len, 68);
        wait_frame("t1b");
        chk("t1_len1",  done_len, 68);

        // 2: cowboy blinks while ready
        set_in(4'd0, 4'd10, 1'b0, 1'b0, 1'b1);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            wait_frame("t2");
            chk("t2_word", {16'd0, done_word}, k[1] ? 32'h0401 : 32'h0400);
        end

        // 3: coinciding positions stay lit
        set_in(4'd7, 4'd7, 1'b0, 1'b0, 1'b1);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            wait_frame("t3");
            chk("t3_word", {16'd0, done_word}, 32'h0080);
        end

        // 4: end screens
        set_in(4'd0, 4'd10, 1'b1, 1'b1, 1'b0);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            wait_frame("t4w");
            chk("t4_won", {16'd0, done_word}, k[1] ? 32'hFFFF : 32'h0000);
        end
        set_in(4'd0, 4'd10, 1'b1, 1'b0, 1'b0);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            wait_frame("t4l");
            chk("t4_lost", {16'd0, done_word}, k[1] ? 32'hAAAA : 32'h5555);
        end

        // 5: input change mid-frame applies to the next frame only
        set_in(4'd0, 4'd10, 1'b0, 1'b0, 1'b0);
        do_reset();
        wait_edges(8);
        dif.horse_pos = 4'd12;
        wait_frame("t5a");
        chk("t5_cur",  {16'd0, done_word}, 32'h0401);
        wait_frame("t5b");
        chk("t5_next", {16'd0, done_word}, 32'h1001);

        // 6: reset in the middle of bit 5
        set_in(4'd15, 4'd3, 1'b0, 1'b0, 1'b0);
        do_reset();
        wait_edges(11);
        chk("t6_clk_hi_before", {31'd0, dif.sr_clk}, 32'd1);
        lr0 = lat_rises;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_clk",   {31'd0, dif.sr_clk},   32'd0);
        chk("t6_rst_data",  {31'd0, dif.sr_data},  32'd0);
        chk("t6_rst_latch", {31'd0, dif.sr_latch}, 32'd0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock); #1;
        chk("t6_data_c1", {31'd0, dif.sr_data}, 32'd0);
        @(posedge clock); #1;
        chk("t6_data_c2", {31'd0, dif.sr_data}, 32'd1);
        wait_frame("t6");
        chk("t6_word",  {16'd0, done_word}, 32'h8008);
        chk("t6_edges", done_edges, 16);
        chk("t6_latches", lat_rises - lr0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
